kpd_scanner: RTL
================

KPD_SCANNER -- requirements
Module: kpd_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column strobe dwells; legal range 4..65535.
REQ-002 Parameter DEBOUNCE, default 4, consecutive matching row samples needed to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 col  output  4  column strobe, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  code of the accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_valid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 key_down  output  1  level; high from press acceptance until release acceptance.

Function
REQ-010 The block SHALL pass row through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rs).
REQ-011 Column index c SHALL map to col as c=0 -> 0111, c=1 -> 1011, c=2 -> 1101, c=3 -> 1110.
REQ-012 Row index r SHALL map from rs as 0111 -> 0, 1011 -> 1, 1101 -> 2, 1110 -> 3; with several bits low, the most-significant low bit SHALL set r.
REQ-013 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; rs SHALL be sampled only when the count equals SCAN_DIV-1.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: at each sample with rs = 1111, c SHALL advance by 1 mod 4 (3 -> 0) and the dwell counter SHALL restart.
REQ-016 SCAN: at a sample with rs != 1111, the block SHALL latch rs as the candidate pattern and freeze c; a match count of 1 SHALL be recorded.
REQ-017 SCAN -> HELD when the match count reaches DEBOUNCE; with DEBOUNCE=1 this happens on the detecting sample; otherwise SCAN -> DEBOUNCE.
REQ-018 DEBOUNCE: each sample equal to the candidate SHALL increment the match count; reaching DEBOUNCE SHALL go to HELD.
REQ-019 DEBOUNCE: any sample differing from the candidate, including 1111 or another non-idle pattern, SHALL abort to SCAN with c advanced by 1 and no output change.
REQ-020 On entry to HELD, key_code SHALL load {r, c} and key_valid SHALL be high for exactly the first cycle after the accepting sample.
REQ-021 key_down SHALL rise in the same cycle as key_valid.
REQ-022 HELD: c SHALL stay frozen; a sample of 1111 SHALL go to RELEASE with a release count of 1; non-1111 samples, including a different pattern, SHALL keep HELD without a new key_valid.
REQ-023 RELEASE: each 1111 sample SHALL increment the release count; any non-1111 sample SHALL return to HELD.
REQ-024 When the release count reaches DEBOUNCE (immediately if DEBOUNCE=1), key_down SHALL fall the next cycle; the FSM SHALL enter SCAN with c advanced by 1.
REQ-025 key_code SHALL hold its last value until the next acceptance.
REQ-026 key_valid SHALL never be high in two consecutive cycles; at most one pulse per press.
REQ-027 Latency from a stable press on the strobed column: key_valid at most DEBOUNCE*SCAN_DIV + 3 cycles after row settles.

Reset
REQ-028 While reset is high at a clk edge: col=0111, key_code=0000, key_valid=0, key_down=0, FSM=SCAN, c=0, dwell/match/release counters=0, synchronizer flops=1111.
REQ-029 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abandon the key with no key_valid pulse; scanning SHALL restart at c=0 the cycle after reset deasserts.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-030 Idle, row=1111 for 40 cycles after reset -> col cycles 0111,1011,1101,1110 every 4 cycles; key_valid never high.
REQ-031 Hold row=1101 while col=1011, for 3 dwells -> one key_valid pulse, key_code=1001 (r=2, c=1), key_down=1, col frozen at 1011.
REQ-032 Release to row=1111 for 2 dwells -> key_down falls; the next strobe is col=1101; no extra key_valid.
REQ-033 Bounce: row=1110 for one sample then 1111 -> no key_valid; col advances.
REQ-034 Row=0110 on column 3 -> key_code=0011 (row 0 priority).
REQ-035 Reset during HELD -> outputs return to reset values next cycle; re-press yields one fresh key_valid.

Source files
------------

// File: rtl/kpd_scanner.sv
// rtl/kpd_scanner.sv - 4x4 keypad column scanner with debounced press/release detection
module kpd_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0] DB_N = 4'(DEBOUNCE);
    localparam logic [3:0] IDLE = 4'b1111;

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, rs;
    logic [CW-1:0] dwell;
    logic [1:0]    c, c_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    code_n;
    logic          valid_n, down_n;
    logic [1:0]    r_idx;
    logic          sample;

    assign sample = (dwell == DWELL_LAST);
    assign col    = ~(4'b1000 >> c);

    // Several rows low at once: the most-significant low bit wins.
    always_comb begin
        r_idx = 2'd3;
        if (!rs[3])      r_idx = 2'd0;
        else if (!rs[2]) r_idx = 2'd1;
        else if (!rs[1]) r_idx = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= IDLE;
            rs        <= IDLE;
            dwell     <= '0;
            state     <= ST_SCAN;
            c         <= 2'd0;
            cnt       <= 4'd0;
            cand      <= IDLE;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            sync1     <= row;
            rs        <= sync1;
            dwell     <= sample ? '0 : dwell + CW'(1);
            state     <= state_n;
            c         <= c_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    always_comb begin
        state_n = state;
        c_n     = c;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        down_n  = key_down;
        if (sample) begin
            unique case (state)
                ST_SCAN: begin
                    if (rs == IDLE) begin
                        c_n = c + 2'd1;
                    end else begin
                        cand_n = rs;
                        cnt_n  = 4'd1;
                        if (DB_N == 4'd1) begin
                            state_n = ST_HELD;
                            code_n  = {r_idx, c};
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                        end else begin
                            state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == cand) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt + 4'd1 == DB_N) begin
                            state_n = ST_HELD;
                            code_n  = {r_idx, c};
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                        end
                    end else begin
                        state_n = ST_SCAN;
                        c_n     = c + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (rs == IDLE) begin
                        cnt_n = 4'd1;
                        if (DB_N == 4'd1) begin
                            state_n = ST_SCAN;
                            c_n     = c + 2'd1;
                            down_n  = 1'b0;
                        end else begin
                            state_n = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rs == IDLE) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt + 4'd1 == DB_N) begin
                            state_n = ST_SCAN;
                            c_n     = c + 2'd1;
                            down_n  = 1'b0;
                        end
                    end else begin
                        state_n = ST_HELD;
                    end
                end
            endcase
        end
    end
endmodule
